// File: rtl/sort_pkg.sv
// Shared types and constants for the in-memory bubble-sort engine and its host front end.
package sort_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned N_DEF      = 16;

  localparam logic MEM_OWNER_HOST = 1'b0;
  localparam logic MEM_OWNER_SORT = 1'b1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } host_state_t;

endpackage

// File: rtl/sort_host_if_if.sv
// Host front-end bundle: input stream, output stream, sorter handshake and host memory port.
interface sort_host_if_if
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              sort_start;
  logic              sort_done;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    input  in_valid, in_data, out_ready, sort_done, mem_rdata,
    output in_ready, out_valid, out_data, sort_start, mem_sel,
           mem_addr, mem_wdata, mem_write, mem_read, busy
  );

  modport slave (
    output in_valid, in_data, out_ready, sort_done, mem_rdata,
    input  in_ready, out_valid, out_data, sort_start, mem_sel,
           mem_addr, mem_wdata, mem_write, mem_read, busy
  );

endinterface

// File: rtl/sort_host_if_elem_counter.sv
// Element counter with synchronous clear and terminal-count flag at N-1.
module elem_counter
  import sort_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned N      = N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  logic [ADDR_W-1:0] r_cnt;

  // Clear wins over increment so the terminal element never wraps past N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/sort_host_if.sv
// Host front end: loads a frame into the shared memory, kicks the sorter, then drains the sorted frame.
module sort_host_if
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned N      = N_DEF
) (
  input logic            clk,
  input logic            rst,
  sort_host_if_if.master bus
);

  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_KICK  = KICK;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_tc;
  logic              w_clr;
  logic              w_inc;

  elem_counter #(
    .ADDR_W (ADDR_W),
    .N      (N)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Moore decode from state/cnt; only mem_write also looks at in_valid.
  always_comb begin
    w_next         = r_state;
    w_clr          = 1'b0;
    w_inc          = 1'b0;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.sort_start = 1'b0;
    bus.mem_sel    = MEM_OWNER_HOST;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.busy       = 1'b0;
    bus.mem_addr   = w_cnt;
    bus.mem_wdata  = bus.in_data;
    bus.out_data   = bus.mem_rdata;

    case (r_state)
      S_LOAD: begin
        bus.in_ready  = 1'b1;
        bus.mem_write = bus.in_valid;
        if (bus.in_valid) begin
          if (w_tc) begin
            w_clr  = 1'b1;
            w_next = S_KICK;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      S_KICK: begin
        // The sorter leaves idle on this edge, so a single-cycle pulse is enough.
        bus.mem_sel    = MEM_OWNER_SORT;
        bus.sort_start = 1'b1;
        bus.busy       = 1'b1;
        w_next         = S_WAIT;
      end
      S_WAIT: begin
        bus.mem_sel = MEM_OWNER_SORT;
        bus.busy    = 1'b1;
        if (bus.sort_done) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.mem_read  = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (w_tc) begin
            w_clr  = 1'b1;
            w_next = S_LOAD;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_host_if.sv
// Scoreboard bench for sort_host_if with a behavioural memory and sorter.
module tb_sort_host_if;
  import sort_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned NN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_host_if_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sort_host_if #(.DATA_W(DW), .ADDR_W(AW), .N(NN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural memory plus sorter: after sort_lat cycles the array is sorted in one step.
  logic [DW-1:0] mem [NN];
  logic [DW-1:0] sq [$];
  logic          s_active;
  logic          s_done;
  logic          sp_done;
  int            s_cnt;
  int            sort_lat;

  assign bus.sort_done = s_done | sp_done;
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_active <= 1'b0;
      s_cnt    <= 0;
      s_done   <= 1'b0;
    end else begin
      s_done <= 1'b0;
      if (bus.mem_sel == MEM_OWNER_HOST && bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      if (s_active) begin
        if (s_cnt <= 1) begin
          sq.delete();
          for (int i = 0; i < NN; i++) sq.push_back(mem[i]);
          sq.sort();
          for (int i = 0; i < NN; i++) mem[i] <= sq[i];
          s_done   <= 1'b1;
          s_active <= 1'b0;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end else if (bus.sort_start) begin
        s_active <= 1'b1;
        s_cnt    <= sort_lat;
      end
    end
  end

  always @(posedge clk) begin
    #1 bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard state
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wr_q  [$];
  int  exp_waddr = 0, h_cnt = 0, n_out = 0, cyc = 0, last_acc = -10;
  bit  prev_stall = 0, prev_start = 0, chk_rdy = 0, exp_drain = 0, saw_start = 0;
  logic [DW-1:0] prev_data;

  // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_waddr = 0; h_cnt = 0; prev_stall = 0; prev_start = 0;
      chk_rdy = 0; exp_drain = 0;
    end else begin
      if (chk_rdy) begin
        check("ready_after_drain", {bus.in_ready, bus.out_valid}, 2'b10);
        chk_rdy = 0;
      end
      if (prev_start) begin
        check("start_one_cycle", {bus.sort_start, bus.mem_sel}, 2'b01);
      end
      if (exp_drain) begin
        check("drain_entry", {bus.out_valid, bus.mem_sel, bus.busy}, 3'b100);
        exp_drain = 0;
      end
      if (bus.mem_write) begin
        check("waddr", bus.mem_addr, exp_waddr);
        check("wsel", bus.mem_sel, MEM_OWNER_HOST);
        if (wr_q.size() == 0) check("wdata_unexpected", 1, 0);
        else check("wdata", bus.mem_wdata, wr_q.pop_front());
        exp_waddr++;
        if (exp_waddr == NN) last_acc = cyc;
      end
      if (bus.sort_start) begin
        check("start_after_n_writes", exp_waddr, NN);
        check("start_timing", cyc, last_acc + 1);
        check("kick_sel_busy", {bus.mem_sel, bus.busy}, 2'b11);
        exp_waddr = 0;
        saw_start = 1;
      end
      prev_start = bus.sort_start;
      if (bus.busy && bus.in_valid) begin
        check("busy_blocks_input", {bus.in_ready, bus.mem_write}, 2'b00);
      end
      if (s_done) begin
        check("done_in_wait", {bus.busy, bus.sort_start}, 2'b10);
        exp_drain = 1;
      end
      if (bus.out_valid) begin
        if (prev_stall) check("stall_stable", bus.out_data, prev_data);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) check("out_unexpected", 1, 0);
          else check("out_data", bus.out_data, exp_q.pop_front());
          n_out++;
          h_cnt++;
          if (h_cnt == NN) begin
            h_cnt = 0;
            chk_rdy = 1;
          end
        end
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    bit acc;
    int budget;
    acc = 0;
    budget = 0;
    wr_q.push_back(d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      budget++;
      if (!acc && budget > 3000) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] w [NN], input bit gaps, input int sp_at);
    logic [DW-1:0] q [$];
    for (int i = 0; i < NN; i++) q.push_back(w[i]);
    q.sort();
    for (int i = 0; i < NN; i++) exp_q.push_back(q[i]);
    for (int i = 0; i < NN; i++) begin
      if (i == sp_at) begin
        sp_done = 1'b1;
        step();
        sp_done = 1'b0;
      end
      send_word(w[i]);
      if (gaps) step();
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      budget++;
      if (budget > 5000) begin
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
    end
    step();
  endtask

  task automatic rand_frame(output logic [DW-1:0] w [NN]);
    for (int i = 0; i < NN; i++) w[i] = DW'($urandom_range(0, 255));
  endtask

  logic [DW-1:0] fw [NN];
  int budget;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    sp_done      = 1'b0;
    sort_lat     = 300;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {bus.in_ready, bus.out_valid, bus.sort_start, bus.mem_sel, bus.busy,
                          bus.mem_write, bus.mem_read}, 7'b1000000);
    check("rst_addr", bus.mem_addr, 0);
    rst = 1'b0;
    step();
    check("post_rst_ready", {bus.in_ready, bus.busy}, 2'b10);

    // Frame A: descending, gapped input, spurious done in LOAD, input held during WAIT
    for (int i = 0; i < NN; i++) fw[i] = DW'(NN - 1 - i);
    send_frame(fw, 1'b1, 5);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    budget = 0;
    while (bus.out_valid !== 1'b1 && budget < 2000) begin
      step();
      budget++;
    end
    check("frame_a_reaches_drain", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    repeat (4) step();
    sp_done = 1'b1;
    step();
    sp_done = 1'b0;
    wait_drain();

    // Frame B: back-to-back, random data, short sort
    sort_lat = $urandom_range(3, 40);
    rand_frame(fw);
    send_frame(fw, 1'b0, -1);
    wait_drain();

    // Frame C: reset 200 cycles into WAIT, frame discarded
    sort_lat  = 1000;
    saw_start = 0;
    rand_frame(fw);
    send_frame(fw, 1'b0, -1);
    budget = 0;
    while (!saw_start && budget < 100) begin
      step();
      budget++;
    end
    check("frame_c_kicked", saw_start, 1);
    repeat (200) step();
    check("frame_c_in_wait", {bus.busy, bus.mem_sel}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_wait", {bus.in_ready, bus.mem_sel, bus.busy, bus.out_valid}, 4'b1000);
    check("rst_mid_wait_addr", bus.mem_addr, 0);
    exp_q.delete();
    wr_q.delete();
    repeat (2) step();
    rst = 1'b0;
    step();

    // Frame D: fixed permutation after the reset
    sort_lat = 50;
    fw = '{8'd3, 8'd9, 8'd1, 8'd14, 8'd7, 8'd0, 8'd12, 8'd5,
           8'd11, 8'd2, 8'd15, 8'd8, 8'd6, 8'd10, 8'd4, 8'd13};
    send_frame(fw, 1'b1, -1);
    wait_drain();

    // Frames E/F: random data, random gaps, with duplicates likely in F
    for (int f = 0; f < 2; f++) begin
      sort_lat = $urandom_range(1, 60);
      rand_frame(fw);
      if (f == 1) for (int i = 0; i < NN; i += 3) fw[i] = 8'h55;
      send_frame(fw, 1'($urandom_range(0, 1)), -1);
      wait_drain();
    end

    repeat (3) step();
    check("total_outputs", n_out, 5 * NN);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sort_host_if.md
Name: sort_host_if

Overview:
- Host-side front end for the in-memory bubble-sort engine; drives the sorter's start/done handshake from the host side.
- Streams an N-word frame in over a valid/ready port and writes it into the shared array memory.
- Pulses start to the sort controller and hands it the memory until done.
- Then reads the sorted array back out over a valid/ready port, ascending address order.

Parameters:
- DATA_W, 8, element width in bits.
- ADDR_W, 4, memory address width.
- N, 16, elements per frame; 2 <= N <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  sorted word.
- out_ready  in  1  downstream accepts out_data.
- sort_start  out  1  start pulse to the sort controller.
- sort_done  in  1  done pulse from the sort controller.
- mem_sel  out  1  memory owner: 0 = this block, 1 = sorter; drives the memory address/data/control mux.
- mem_addr  out  ADDR_W  host-side address.
- mem_wdata  out  DATA_W  host-side write data.
- mem_write  out  1  host-side write enable.
- mem_read  out  1  host-side read enable.
- mem_rdata  in  DATA_W  memory read data; combinational w.r.t. mem_addr.
- busy  out  1  high in KICK or WAIT.

Behaviour:
- Memory model: combinational read, write on the clk rising edge when write is high.
- FSM states: LOAD, KICK, WAIT, DRAIN. Reset enters LOAD with cnt = 0.
- cnt is an ADDR_W-bit element counter.
- Reset values:
  - in_ready = 1.
  - out_valid, sort_start, mem_sel, mem_write, mem_read, busy = 0.
  - mem_addr = 0; out_data = mem_rdata (don't care).
- All outputs are decoded combinationally from state and cnt (Moore), except mem_write = in_valid & in_ready.
- LOAD:
  - in_ready = 1, mem_sel = 0, mem_addr = cnt, mem_wdata = in_data.
  - On accept (in_valid & in_ready): write the word; if cnt == N-1, clear cnt and go to KICK, else cnt+1.
  - No accept: hold state and cnt.
- KICK:
  - Lasts exactly 1 cycle: mem_sel = 1, sort_start = 1, in_ready = 0, busy = 1.
  - Always goes to WAIT.
  - One pulse suffices because the sorter leaves idle on the edge where start is high.
- WAIT:
  - mem_sel = 1, busy = 1, in_ready = 0; no host memory access.
  - sort_done = 1 -> DRAIN; cnt is already 0.
  - No timeout; the block waits indefinitely.
- DRAIN:
  - mem_sel = 0, mem_read = 1, mem_addr = cnt, out_valid = 1, out_data = mem_rdata.
  - out_data is stable while out_ready = 0.
  - On out_valid & out_ready: if cnt == N-1, clear cnt and go to LOAD, else cnt+1.
- Boundary conditions:
  - sort_done outside WAIT: ignored.
  - sort_done coincident with the KICK cycle: ignored; the sorter cannot finish in 0 cycles.
  - in_valid outside LOAD: not accepted; no write.
  - out_ready outside DRAIN: no effect.
  - Back-to-back frames: the cycle after the last DRAIN handshake, in_ready = 1 and the next frame's word 0 may be accepted.
  - cnt never wraps past N-1; for N = 2**ADDR_W the clear at N-1 coincides with natural wrap.
- Reset mid-operation (any state): immediate return to LOAD, cnt = 0, mem_sel = 0, so the memory is reclaimed from the sorter.
  - The sorter shares rst and is reset concurrently.
  - Partial frame contents are discarded logically; memory is not cleared.

Decomposition:
- Shared package sort_pkg:
  - host_state_t enum {LOAD, KICK, WAIT, DRAIN}.
  - Default DATA_W/ADDR_W constants, shared with the sort controller/datapath.
  - MEM_OWNER_HOST = 0, MEM_OWNER_SORT = 1.
- One natural sub-module: elem_counter (ADDR_W-bit counter with clr, inc, terminal-count output tc = (cnt == N-1)).
  - Same style as the sorter's pointer counters; instantiated once here.

Test Plan:
- Reset check: assert rst 3 cycles -> in_ready = 1, out_valid = 0, sort_start = 0, mem_sel = 0, busy = 0.
- Load with gaps: feed 15,14,...,0 (N = 16), in_valid toggling 1/0 -> writes to addr 0..15 in order, exactly 16 mem_write cycles; sort_start high for exactly one cycle, the cycle after the 16th accept; mem_sel = 1 from that cycle.
- WAIT stall:
  - Hold in_valid = 1 with in_data = 0xAA throughout WAIT -> in_ready = 0, no mem_write.
  - Behavioural sorter pulses sort_done after 300 cycles -> state DRAIN next cycle, mem_sel = 0.
- Drain with backpressure: random out_ready (50%) -> output sequence 0,1,...,15 exactly once each; out_data stable while stalled; in_ready = 1 the cycle after the 16th handshake.
- Spurious done: pulse sort_done during LOAD (after 5 words) and in DRAIN -> no state change, no duplicate or skipped output.
- Reset mid-WAIT: assert rst 200 cycles into WAIT -> LOAD, cnt = 0, mem_sel = 0 immediately; next full 16-word frame sorts and drains correctly (e.g. 3,9,1,... -> ascending).
